// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage feeding the control decoder. Holds the PC, issues a
// single outstanding read to instruction memory, buffers the returned word and
// computes the next PC from the decoder's selects once the buffered
// instruction is consumed.
//
// Handshake: imem_req/imem_addr are held stable from the cycle the request is
// raised until the cycle imem_ready is seen high; the word on imem_rdata is
// taken only in a cycle with imem_req & imem_ready. The buffered instruction
// is consumed in any cycle where instr_valid=1 and stall=0; the decoder
// selects, branch_taken, imm and rs_val are sampled only in that cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   imem_req, imem_addr   fetch request / word-aligned fetch address
//   imem_ready, imem_rdata memory accept strobe / returned instruction word
//   instr, op, fn         buffered instruction and its decoder fields
//   pc_out, pc_plus4      address of buffered instruction and its successor
//   instr_valid           instr holds an unconsumed instruction
//   stall                 downstream not ready, hold everything
//   selbrjumpz, selpctype decoder next-PC selects
//   branch_taken          comparator result for conditional branches
//   imm                   sign-extended word offset for branches
//   rs_val                register target for JR
//   addr_err              sticky misaligned-target flag
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        op,
    output logic [5:0]        fn,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc_plus4,
    output logic              instr_valid,
    input  logic              stall,
    input  logic [1:0]        selbrjumpz,
    input  logic [1:0]        selpctype,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rs_val,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic              req_q;
    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] next_pc;

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_q + 32'd4;      // wraps modulo 2^32
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign fn          = instr_q[5:0];
    assign instr_valid = valid_q;
    assign addr_err    = err_q;

    // Next-PC selection. Only the taken PC-relative branch and the two jump
    // forms redirect; every other select combination falls through to pc+4.
    always_comb begin
        next_pc = pc_plus4;
        case (selbrjumpz)
            2'b10: begin
                if (selpctype == 2'b00 && branch_taken)
                    next_pc = pc_plus4 + (imm << 2);
            end
            2'b01: begin
                if (selpctype == 2'b01)
                    next_pc = rs_val;
                else if (selpctype == 2'b10)
                    next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            end
            default: next_pc = pc_plus4;
        endcase
    end

    // Control FSM. imem_req and instr_valid are registered alongside the
    // state so they are exactly (state==FETCH) and (state==FULL).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
                        // A misaligned target never gets fetched; the PC stays
                        // on the offending instruction for debug.
                        if (next_pc[1:0] != 2'b00) begin
                            err_q <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            pc_q  <= next_pc;
                            req_q <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_ERR: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage with RESET_PC=0x100. A single initial block
// walks the design through sequential fetch, branches, jumps, a stall window,
// the misaligned-target error and an asynchronous reset mid-fetch. Outputs are
// sampled 1 time unit after each rising edge, then inputs for the next edge
// are driven.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        stall;
    logic [1:0]  selbrjumpz;
    logic [1:0]  selpctype;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(
        .RESET_PC(32'h0000_0100),
        .DATA_W  (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .fn          (fn),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .stall       (stall),
        .selbrjumpz  (selbrjumpz),
        .selpctype   (selpctype),
        .branch_taken(branch_taken),
        .imm         (imm),
        .rs_val      (rs_val),
        .addr_err    (addr_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called while the DUT is in FETCH: checks the request, returns a word
    // with ready high and checks the buffered instruction one edge later.
    task automatic fetch_word(input logic [31:0] addr, input logic [31:0] word);
        chk1("req_in_fetch", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, addr);
        chk1("valid_in_fetch", instr_valid, 1'b0);
        imem_rdata = word;
        imem_ready = 1'b1;
        step();
        chk1("valid_in_full", instr_valid, 1'b1);
        chk("instr_captured", instr, word);
        chk("pc_out_full", pc_out, addr);
        chk("pc_plus4_full", pc_plus4, addr + 32'd4);
        chk1("req_in_full", imem_req, 1'b0);
        chk("op_field", {26'b0, op}, {26'b0, word[31:26]});
        chk("fn_field", {26'b0, fn}, {26'b0, word[5:0]});
    endtask

    // Consume the buffered instruction with the given decoder selects.
    task automatic consume(input logic [1:0] bj, input logic [1:0] pt, input logic tk,
                           input logic [31:0] immv, input logic [31:0] rsv);
        selbrjumpz   = bj;
        selpctype    = pt;
        branch_taken = tk;
        imm          = immv;
        rs_val       = rsv;
        stall        = 1'b0;
        step();
        selbrjumpz   = 2'b00;
        selpctype    = 2'b00;
        branch_taken = 1'b0;
        imm          = 32'h0;
        rs_val       = 32'h0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n        = 1'b0;
        imem_ready   = 1'b1;
        imem_rdata   = 32'h0;
        stall        = 1'b0;
        selbrjumpz   = 2'b00;
        selpctype    = 2'b00;
        branch_taken = 1'b0;
        imm          = 32'h0;
        rs_val       = 32'h0;

        step();
        step();
        // Reset state
        chk("rst_pc_out", pc_out, 32'h0000_0100);
        chk("rst_instr", instr, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_err", addr_err, 1'b0);
        chk("rst_op", {26'b0, op}, 32'h0);
        chk("rst_fn", {26'b0, fn}, 32'h0);

        rst_n = 1'b1;
        chk1("idle_no_req", imem_req, 1'b0);
        step();   // IDLE -> FETCH, first request one cycle after release

        // Sequential fetch with ready tied high: 0x100, 0x104, 0x108
        fetch_word(32'h0000_0100, 32'h2108_0001);
        consume(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        fetch_word(32'h0000_0104, 32'h2129_0002);
        // 11/11 selects are treated as sequential
        consume(2'b11, 2'b11, 1'b1, 32'h0000_0040, 32'h0000_0800);
        // JR to 0x200
        fetch_word(32'h0000_0108, 32'h0200_0008);
        consume(2'b01, 2'b01, 1'b0, 32'h0, 32'h0000_0200);

        // BEQ at 0x200, imm=-2, taken: 0x204 - 8 = 0x1FC
        fetch_word(32'h0000_0200, 32'h1000_FFFE);
        consume(2'b10, 2'b00, 1'b1, 32'hFFFF_FFFE, 32'h0);
        fetch_word(32'h0000_01FC, 32'h0000_0020);
        consume(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        // Same BEQ, not taken: 0x204
        fetch_word(32'h0000_0200, 32'h1000_FFFE);
        consume(2'b10, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0);
        // JR to 0x3000_0010
        fetch_word(32'h0000_0204, 32'h0200_0008);
        consume(2'b01, 2'b01, 1'b0, 32'h0, 32'h3000_0010);
        // J with index 0x40: {0x3, 0x40, 00} = 0x3000_0100
        fetch_word(32'h3000_0010, 32'h0800_0040);
        consume(2'b01, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEE0);
        // JR to the top word of the address space
        fetch_word(32'h3000_0100, 32'h0200_0008);
        consume(2'b01, 2'b01, 1'b0, 32'h0, 32'hFFFF_FFFC);
        // pc+4 wraps to 0
        fetch_word(32'hFFFF_FFFC, 32'h0000_0021);
        chk("pc_plus4_wrap", pc_plus4, 32'h0);
        consume(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);

        // Stall window in FULL with the selects changing every cycle
        fetch_word(32'h0000_0000, 32'h0200_0008);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            selbrjumpz = (i == 1) ? 2'b10 : 2'b01;
            selpctype  = 2'(i);
            branch_taken = 1'b1;
            imm        = 32'h0000_0100;
            rs_val     = 32'h1234_0000 + 32'(i * 4);
            step();
            chk1("stall_valid", instr_valid, 1'b1);
            chk("stall_pc", pc_out, 32'h0);
            chk("stall_instr", instr, 32'h0200_0008);
            chk1("stall_no_req", imem_req, 1'b0);
        end
        // Redirect uses only the values present on the stall=0 cycle
        consume(2'b01, 2'b01, 1'b0, 32'h0, 32'h8000_0020);
        chk("redirect_after_stall", imem_addr, 32'h8000_0020);

        // JR to a misaligned target -> sticky error
        fetch_word(32'h8000_0020, 32'h0200_0008);
        consume(2'b01, 2'b01, 1'b0, 32'h0, 32'h8000_0022);
        chk1("err_flag", addr_err, 1'b1);
        chk1("err_no_req", imem_req, 1'b0);
        chk1("err_no_valid", instr_valid, 1'b0);
        chk("err_pc_held", pc_out, 32'h8000_0020);
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            stall      = 1'($urandom_range(0, 1));
            selbrjumpz = 2'($urandom_range(0, 3));
            step();
            chk1("err_sticky", addr_err, 1'b1);
            chk1("err_sticky_req", imem_req, 1'b0);
        end

        // Reset clears the error and restarts at RESET_PC
        stall = 1'b0;
        selbrjumpz = 2'b00;
        imem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk1("rst2_err_clear", addr_err, 1'b0);
        chk("rst2_pc", pc_out, 32'h0000_0100);
        step();
        rst_n = 1'b1;
        step();
        fetch_word(32'h0000_0100, 32'hAAAA_0001);
        consume(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);

        // Memory not ready for 5 cycles: request and address held stable,
        // the word on imem_rdata is not captured
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, 32'h0000_0104);
            chk1("wait_valid", instr_valid, 1'b0);
            chk("wait_instr_held", instr, 32'hAAAA_0001);
        end
        fetch_word(32'h0000_0104, 32'h5555_0002);
        consume(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);

        // Async reset mid-FETCH with memory not ready
        imem_ready = 1'b0;
        step();
        chk1("pre_rst_req", imem_req, 1'b1);
        chk("pre_rst_addr", imem_addr, 32'h0000_0108);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_req_drop", imem_req, 1'b0);
        chk("async_rst_pc", pc_out, 32'h0000_0100);
        chk("async_rst_instr", instr, 32'h0);
        step();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        chk1("restart_idle_req", imem_req, 1'b0);
        step();
        fetch_word(32'h0000_0100, 32'h0C00_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of the control decoder.
- Holds the PC, issues one-outstanding-request reads to instruction memory, and buffers the returned word.
- Presents op/fn fields to the decoder.
- Computes the next PC from the decoder's selbrjumpz/selpctype outputs plus the comparator result, once the current instruction is consumed.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
DATA_W, 32, instruction/address width (fixed 32; other values unsupported)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address (word aligned)
imem_ready  in  1  memory accepts/returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_req & imem_ready
instr  out  32  buffered instruction
op  out  6  instr[31:26], to decoder op
fn  out  6  instr[5:0], to decoder fn
pc_out  out  32  address of buffered instruction
pc_plus4  out  32  pc_out + 4
instr_valid  out  1  instr holds a valid, unconsumed instruction
stall  in  1  downstream not ready; instruction not consumed while high
selbrjumpz  in  2  decoder: 00 sequential, 01 unconditional jump, 10 conditional branch, 11 treated as 00
selpctype  in  2  decoder: 00 PC+imm, 01 RS, 10 index, 11 treated as sequential
branch_taken  in  1  comparator result for conditional branch
imm  in  32  sign-extended 16-bit offset (words)
rs_val  in  32  register RS value (JR target)
addr_err  out  1  sticky misaligned-target flag

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, pc_out=RESET_PC.
  - instr=0, instr_valid=0, imem_req=0, addr_err=0.
  - Any in-flight request is abandoned immediately.
- States: IDLE, FETCH, FULL, ERR.
- IDLE: entered only from reset; imem_req=0; next cycle -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc_out.
  - Request and address held stable until imem_ready=1.
  - On imem_req & imem_ready: instr<=imem_rdata, -> FULL.
  - imem_ready while imem_req=0 is ignored.
- FULL:
  - instr_valid=1, imem_req=0.
  - Control inputs are sampled only in FULL with stall=0 (the consume cycle). If stall=1, all state and outputs are held.
  - On consume: pc_out<=next_pc, instr_valid<=0, -> FETCH. If next_pc[1:0]!=0: addr_err<=1, -> ERR, pc_out unchanged.
- next_pc:
  - sequential: pc_plus4.
  - selbrjumpz=10 & selpctype=00 & branch_taken: pc_plus4 + (imm<<2).
  - selbrjumpz=10 & !branch_taken: pc_plus4.
  - selbrjumpz=01 & selpctype=01: rs_val.
  - selbrjumpz=01 & selpctype=10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Any other combination: pc_plus4.
- Arithmetic:
  - All adds are modulo 2^32 with no overflow detection.
  - pc_plus4 at 32'hFFFF_FFFC wraps to 0.
  - Branch offsets wrap likewise.
- No branch delay slot: the instruction after a taken branch or jump is never fetched.
- ERR: imem_req=0, instr_valid=0, addr_err=1; held until reset.
- Latency: at most one instruction per 2 cycles when imem_ready is tied high.
  - Request cycle; FULL cycle consumed -> next request the following cycle.
- op/fn are combinational slices of instr and are 0 in reset.

Test Plan:
- Reset with RESET_PC=0x100, imem_ready=1, stall=0, all selects 00 -> imem_addr sequence 0x100, 0x104, 0x108; instr_valid high every second cycle; first request one cycle after reset release.
- imem_ready held low for 5 cycles in FETCH -> imem_req and imem_addr=0x104 stable throughout; instr captured on the ready cycle only.
- Consumption of BEQ at 0x200:
  - imm=0xFFFF_FFFE, taken -> next imem_addr=0x1FC.
  - Same with branch_taken=0 -> 0x204.
- Jump variants:
  - J at 0x3000_0010 with instr[25:0]=0x40 -> fetch 0x3000_0100.
  - JR with rs_val=0x8000_0020 -> fetch 0x8000_0020.
  - JR with rs_val=0x8000_0022 -> addr_err=1, imem_req=0, sticky until rst_n low.
- stall=1 for 3 cycles in FULL with selbrjumpz=01 changing -> pc_out/instr unchanged, no request; redirect uses values sampled on the stall=0 cycle.
- Edge cases:
  - pc_out=0xFFFF_FFFC, sequential -> next fetch 0x0.
  - rst_n asserted mid-FETCH with imem_ready low -> imem_req drops immediately; restart fetches RESET_PC.
